router_pkt_tx: RTL
==================

// Module: router_pkt_tx
// PURPOSE
//  Packet source for the router input port; the transmit end of the router receive datapath.
//  Frames each packet as: header {len[5:0],addr[1:0]}, len payload bytes, then one XOR parity byte.
//  packet_valid is high for the header and payload bytes and low for the parity byte.
//  Stalls on router busy. Drives router stimulus and the upstream host interface.
// PARAMETERS
//  ADDR_W      2   destination field width (header bits [1:0])
//  LEN_W       6   payload length field width (header bits [7:2]); legal len 1..63
//  MAX_ADDR    2   highest legal destination; larger addr is rejected
//  GAP_CYCLES  1   minimum idle cycles after the parity byte is accepted before ready returns
// PORTS
//  clock          in   1  single clock, rising edge
//  reset          in   1  synchronous, active-high
//  start          in   1  request a packet; sampled only when ready=1
//  dest_addr      in   2  destination, sampled with start
//  payload_len    in   6  payload byte count, sampled with start
//  corrupt_parity in   1  sampled with start; 1 = send inverted parity (~parity)
//  payload_data   in   8  first-word-fall-through payload byte; valid whenever payload_rd=1
//  payload_rd     out  1  combinational; pops payload_data this cycle
//  busy           in   1  router stall; the current byte is held while busy=1
//  data_out       out  8  byte to router (registered)
//  packet_valid   out  1  registered
//  ready          out  1  high in IDLE only
//  done           out  1  1-cycle pulse when the parity byte is accepted
//  start_err      out  1  1-cycle pulse when start is rejected (len=0 or addr>MAX_ADDR)
// BEHAVIOUR
//  Reset: state=IDLE; data_out=0, packet_valid=0, done=0, start_err=0, parity=0; ready=1 next cycle.
//  Reset mid-packet: aborts immediately with no parity byte. Reset wins over every other input.
//  Accept rule: the current byte is accepted on any cycle with busy=0 and state in HEADER/PAYLOAD/PARITY.
//  IDLE: start & legal -> HEADER.
//    data_out<=header, packet_valid<=1, parity<=header, remain<=len, latch corrupt_parity.
//  IDLE: start & illegal -> stay IDLE, start_err pulse. start outside IDLE is ignored.
//  HEADER, accept -> PAYLOAD.
//    payload_rd=1, data_out<=payload_data, parity^=payload_data, remain<=remain-1.
//  PAYLOAD, accept, remain!=0 -> load next byte exactly as in HEADER.
//  PAYLOAD, accept, remain==0 -> PARITY.
//    data_out<=parity (or ~parity), packet_valid<=0, payload_rd=0.
//  PARITY, accept -> GAP.
//    data_out<=0, done pulse, gap counter<=GAP_CYCLES-1.
//  GAP: counter reaches 0 -> IDLE.
//  Latency: header appears the cycle after start. With busy=0 throughout, a packet occupies len+2 cycles.
//  Stall: busy=1 freezes data_out, packet_valid, remain and parity; payload_rd=0.
//  remain is LEN_W bits, counts down only, never wraps; a 63-byte packet yields exactly 63 payload_rd.
//  Parity is an 8-bit XOR over the header and all payload bytes.
// STRUCTURE
//  router_pkg: state enum {IDLE,HEADER,PAYLOAD,PARITY,GAP},
//    header field offsets/widths, MAX_ADDR default.
//  Sub-module router_parity_gen: 8-bit XOR accumulator with load/xor/hold controls.
//    Shared with the receive side. Everything else stays in one always_ff FSM plus comb payload_rd.
// TESTING
//  1 start addr=1 len=3, payload 11,22,33, busy=0
//    -> data_out 0D,11,22,33 (pv=1) then 0D (pv=0); done pulses; ready after 1 gap cycle.
//  2 same packet, busy=1 for 2 cycles while 22 is presented
//    -> 22 held 3 cycles, payload_rd=0 while busy, the rest as in 1.
//  3 start len=0, and separately addr=3
//    -> start_err pulse, pv stays 0, ready stays 1, no payload_rd.
//  4 case 1 with corrupt_parity=1 -> parity byte F2.
//  5 len=63 addr=2 -> header FE, exactly 63 payload_rd pulses, then parity, no counter wrap.
//  6 reset asserted during payload byte 2
//    -> next cycle pv=0, data_out=00, ready=1; start held high through GAP is ignored until ready.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet datapath.
// Header layout: {len[5:0], addr[1:0]}.
package router_pkg;

    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 2;
    localparam int LEN_W        = 6;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = ADDR_W;
    localparam int MAX_ADDR_DEF = 2;
    localparam int GAP_DEF      = 1;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_e;

    function automatic logic [DATA_W-1:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_parity_gen.sv
// 8-bit XOR accumulator for packet parity.
// load restarts the sum, xor folds in a byte, otherwise holds.
module router_parity_gen
    import router_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              xor_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] parity_o
);

    logic [DATA_W-1:0] parity_q;
    logic [DATA_W-1:0] parity_d;

    // Next accumulator value; load has priority over xor.
    always_comb begin
        parity_d = parity_q;
        if (load_i) begin
            parity_d = data_i;
        end else if (xor_i) begin
            parity_d = parity_q ^ data_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_o = parity_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: header, payload bytes, parity byte.
// Holds the current byte while the router reports busy.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_ADDR   = MAX_ADDR_DEF,
    parameter int GAP_CYCLES = GAP_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic              corrupt_parity,
    input  logic [DATA_W-1:0] payload_data,
    output logic              payload_rd,
    input  logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              packet_valid,
    output logic              ready,
    output logic              done,
    output logic              start_err
);

    localparam int GW = (GAP_CYCLES > 1) ?
                        $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD =
        GW'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] MAX_A =
        ADDR_W'(MAX_ADDR);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pv_q, pv_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              corrupt_q, corrupt_d;
    logic [GW-1:0]     gap_q, gap_d;

    logic              legal;
    logic              par_load;
    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] par_din;
    logic [DATA_W-1:0] parity;

    assign header = make_header(payload_len, dest_addr);
    assign legal  = (payload_len != '0) &&
                    (dest_addr <= MAX_A);

    // Pop a payload byte whenever the byte on the wire
    // is accepted and the next one is payload.
    always_comb begin
        payload_rd = 1'b0;
        if (!busy) begin
            payload_rd = (state_q == HEADER) ||
                         ((state_q == PAYLOAD) &&
                          (remain_q != '0));
        end
    end

    assign par_load = (state_q == IDLE) && start && legal;
    assign par_din  = par_load ? header : payload_data;

    router_parity_gen u_parity (
        .clk_i    (clock),
        .rst_i    (reset),
        .load_i   (par_load),
        .xor_i    (payload_rd),
        .data_i   (par_din),
        .parity_o (parity)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        pv_d      = pv_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        remain_d  = remain_q;
        corrupt_d = corrupt_q;
        gap_d     = gap_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        data_d    = header;
                        pv_d      = 1'b1;
                        remain_d  = payload_len;
                        corrupt_d = corrupt_parity;
                        state_d   = HEADER;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    data_d   = payload_data;
                    remain_d = remain_q - LEN_W'(1);
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    if (remain_q != '0) begin
                        data_d   = payload_data;
                        remain_d = remain_q - LEN_W'(1);
                    end else begin
                        data_d  = corrupt_q ? ~parity : parity;
                        pv_d    = 1'b0;
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    data_d  = '0;
                    done_d  = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any packet.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            pv_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            remain_q  <= '0;
            corrupt_q <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            pv_q      <= pv_d;
            done_q    <= done_d;
            err_q     <= err_d;
            remain_q  <= remain_d;
            corrupt_q <= corrupt_d;
            gap_q     <= gap_d;
        end
    end

    assign data_out     = data_q;
    assign packet_valid = pv_q;
    assign ready        = (state_q == IDLE);
    assign done         = done_q;
    assign start_err    = err_q;

endmodule
